// File: rtl/mips_encode_pkg.sv
// Shared constants for the MIPS instruction encoder.
//   KIND_*     : req_kind encodings (values 5..7 are illegal)
//   OP_LUI/ORI : primary opcodes used to expand the LI pseudo-instruction
//   state_e    : encoder FSM states
package mips_encode_pkg;

   localparam logic [2:0] KIND_R  = 3'd0;
   localparam logic [2:0] KIND_I  = 3'd1;
   localparam logic [2:0] KIND_J  = 3'd2;
   localparam logic [2:0] KIND_LI = 3'd3;
   localparam logic [2:0] KIND_BR = 3'd4;

   localparam logic [5:0] OP_LUI = 6'h0f;
   localparam logic [5:0] OP_ORI = 6'h0d;

   typedef enum logic [1:0] {
      StIdle,
      StEmit1,
      StEmit2
   } state_e;

   function automatic logic kind_legal(input logic [2:0] kind);
      return kind <= KIND_BR;
   endfunction

endpackage

// File: rtl/mips_encode_if.sv
// Request / output bus of the MIPS encoder.
//   req_*      : request handshake and instruction fields
//   base_load  : load base_addr into the address counter (honoured in idle only)
//   out_*      : encoded word stream with word address and last-word flag
//   err        : one-cycle pulse after an illegal request is accepted
// slave modport is the encoder side, master modport the requester/consumer side.
interface mips_encode_if #(
   parameter int unsigned ADDR_W = 30
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_kind;
   logic [5:0]        req_op;
   logic [5:0]        req_funct;
   logic [4:0]        req_rs;
   logic [4:0]        req_rt;
   logic [4:0]        req_rd;
   logic [4:0]        req_shamt;
   logic [31:0]       req_imm;
   logic [25:0]       req_target;
   logic              base_load;
   logic [ADDR_W-1:0] base_addr;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_word;
   logic [ADDR_W-1:0] out_addr;
   logic              out_last;
   logic              err;

   modport slave (
      input  req_valid, req_kind, req_op, req_funct, req_rs, req_rt, req_rd, req_shamt,
             req_imm, req_target, base_load, base_addr, out_ready,
      output req_ready, out_valid, out_word, out_addr, out_last, err
   );

   modport master (
      output req_valid, req_kind, req_op, req_funct, req_rs, req_rt, req_rd, req_shamt,
             req_imm, req_target, base_load, base_addr, out_ready,
      input  req_ready, out_valid, out_word, out_addr, out_last, err
   );
endinterface

// File: rtl/mips_encode_fmt.sv
// Combinational field packing for one request.
//   inputs : kind and raw instruction fields
//   word1  : first word emitted, word2 : second word (valid when two_words)
//   legal  : kind is one of the defined encodings
module mips_encode_fmt
   import mips_encode_pkg::*;
(
   input  logic [2:0]  kind,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [31:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word1,
   output logic [31:0] word2,
   output logic        two_words,
   output logic        legal
);

   always_comb begin
      word1     = '0;
      word2     = '0;
      two_words = 1'b0;
      legal     = kind_legal(kind);
      case (kind)
         KIND_R:  word1 = {6'b0, rs, rt, rd, shamt, funct};
         KIND_I:  word1 = {op, rs, rt, imm[15:0]};
         KIND_J:  word1 = {op, target};
         KIND_BR: begin
            // Branch followed by a NOP for the delay slot.
            word1     = {op, rs, rt, imm[15:0]};
            two_words = 1'b1;
         end
         KIND_LI: begin
            // Pick the shortest expansion: ORI alone, LUI alone, or LUI+ORI.
            if (imm[31:16] == 16'h0) begin
               word1 = {OP_ORI, 5'd0, rt, imm[15:0]};
            end else if (imm[15:0] == 16'h0) begin
               word1 = {OP_LUI, 5'd0, rt, imm[31:16]};
            end else begin
               word1     = {OP_LUI, 5'd0, rt, imm[31:16]};
               word2     = {OP_ORI, rt, rt, imm[15:0]};
               two_words = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_encode.sv
// MIPS instruction encoder: accepts one request at a time, emits its one or two
// encoded words with a running word address.
//   clk, rst_b : clock, asynchronous active-low reset
//   bus        : request/output bus (slave side), see mips_encode_if
module mips_encode
   import mips_encode_pkg::*;
#(
   parameter int unsigned ADDR_W = 30
) (
   input  logic         clk,
   input  logic         rst_b,
   mips_encode_if.slave bus
);

   state_e            state_q, state_d;
   logic [31:0]       word1_q, word2_q;
   logic              two_q;
   logic [ADDR_W-1:0] addr_q;
   logic              err_q;

   logic [31:0] fmt_word1, fmt_word2;
   logic        fmt_two, fmt_legal;
   logic        accept, handshake;

   mips_encode_fmt u_fmt (
      .kind      (bus.req_kind),
      .op        (bus.req_op),
      .funct     (bus.req_funct),
      .rs        (bus.req_rs),
      .rt        (bus.req_rt),
      .rd        (bus.req_rd),
      .shamt     (bus.req_shamt),
      .imm       (bus.req_imm),
      .target    (bus.req_target),
      .word1     (fmt_word1),
      .word2     (fmt_word2),
      .two_words (fmt_two),
      .legal     (fmt_legal)
   );

   assign accept    = (state_q == StIdle) && bus.req_valid;
   assign handshake = (state_q != StIdle) && bus.out_ready;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept && fmt_legal) state_d = StEmit1;
         StEmit1: if (bus.out_ready) state_d = two_q ? StEmit2 : StIdle;
         StEmit2: if (bus.out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.req_ready = (state_q == StIdle);
      bus.out_valid = (state_q != StIdle);
      bus.out_last  = ((state_q == StEmit1) && !two_q) || (state_q == StEmit2);
      bus.out_addr  = addr_q;
      bus.err       = err_q;
      case (state_q)
         StEmit1: bus.out_word = word1_q;
         StEmit2: bus.out_word = word2_q;
         default: bus.out_word = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         word1_q <= '0;
         word2_q <= '0;
         two_q   <= 1'b0;
         addr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= accept && !fmt_legal;
         if (accept && fmt_legal) begin
            word1_q <= fmt_word1;
            word2_q <= fmt_word2;
            two_q   <= fmt_two;
         end
         // A base load in idle lands before the first word of a request
         // accepted in the same cycle, so that word uses the new base.
         if ((state_q == StIdle) && bus.base_load) begin
            addr_q <= bus.base_addr;
         end else if (handshake) begin
            addr_q <= addr_q + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mips_encode.sv
module tb_mips_encode;

   localparam int unsigned AW = 30;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   int   n_vec = 0;
   int   n_miss = 0;
   logic [AW-1:0] m_addr = '0;

   always #5 clk = ~clk;

   mips_encode_if #(.ADDR_W(AW)) bus ();

   mips_encode #(.ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic longint unsigned fld(input longint unsigned v, input int sh);
      return v * (64'd1 << sh);
   endfunction

   // Reference: list of words a request must produce, from the instruction formats.
   function automatic void model(input int kind, input int op, input int funct, input int rs,
                                 input int rt, input int rd, input int shamt,
                                 input logic [31:0] imm, input int target,
                                 output logic [31:0] w0, output logic [31:0] w1,
                                 output int n);
      longint unsigned hi, lo;
      hi = longint'(imm) / 65536;
      lo = longint'(imm) % 65536;
      w0 = '0;
      w1 = '0;
      n  = 0;
      case (kind)
         0: begin
            w0 = 32'(fld(rs, 21) + fld(rt, 16) + fld(rd, 11) + fld(shamt, 6) + funct);
            n  = 1;
         end
         1: begin
            w0 = 32'(fld(op, 26) + fld(rs, 21) + fld(rt, 16) + lo);
            n  = 1;
         end
         2: begin
            w0 = 32'(fld(op, 26) + target);
            n  = 1;
         end
         3: begin
            if (hi == 0) begin
               w0 = 32'(fld(13, 26) + fld(rt, 16) + lo);
               n  = 1;
            end else if (lo == 0) begin
               w0 = 32'(fld(15, 26) + fld(rt, 16) + hi);
               n  = 1;
            end else begin
               w0 = 32'(fld(15, 26) + fld(rt, 16) + hi);
               w1 = 32'(fld(13, 26) + fld(rt, 21) + fld(rt, 16) + lo);
               n  = 2;
            end
         end
         4: begin
            w0 = 32'(fld(op, 26) + fld(rs, 21) + fld(rt, 16) + lo);
            w1 = 32'h0;
            n  = 2;
         end
         default: n = 0;
      endcase
   endfunction

   task automatic scramble_req();
      bus.req_kind   = 3'($urandom);
      bus.req_op     = 6'($urandom);
      bus.req_funct  = 6'($urandom);
      bus.req_rs     = 5'($urandom);
      bus.req_rt     = 5'($urandom);
      bus.req_rd     = 5'($urandom);
      bus.req_shamt  = 5'($urandom);
      bus.req_imm    = $urandom;
      bus.req_target = 26'($urandom);
   endtask

   task automatic send(input int kind, input int op, input int funct, input int rs, input int rt,
                       input int rd, input int shamt, input logic [31:0] imm, input int target,
                       input bit do_base, input logic [AW-1:0] base, input int s1, input int s2);
      logic [31:0] w0, w1, w;
      int n, stall;
      model(kind, op, funct, rs, rt, rd, shamt, imm, target, w0, w1, n);
      check_eq("req_ready_idle", 64'(bus.req_ready), 64'd1);
      bus.req_kind   = 3'(kind);
      bus.req_op     = 6'(op);
      bus.req_funct  = 6'(funct);
      bus.req_rs     = 5'(rs);
      bus.req_rt     = 5'(rt);
      bus.req_rd     = 5'(rd);
      bus.req_shamt  = 5'(shamt);
      bus.req_imm    = imm;
      bus.req_target = 26'(target);
      bus.req_valid  = 1'b1;
      bus.base_load  = do_base;
      bus.base_addr  = base;
      bus.out_ready  = 1'b0;
      step();
      if (do_base) m_addr = base;
      if (n == 0) begin
         bus.req_valid = 1'b0;
         bus.base_load = 1'b0;
         check_eq("err_pulse", 64'(bus.err), 64'd1);
         check_eq("illegal_no_valid", 64'(bus.out_valid), 64'd0);
         check_eq("illegal_ready", 64'(bus.req_ready), 64'd1);
         step();
         check_eq("err_clear", 64'(bus.err), 64'd0);
         check_eq("illegal_no_valid2", 64'(bus.out_valid), 64'd0);
         return;
      end
      // Keep a competing request and base load asserted while busy: both must be ignored.
      scramble_req();
      bus.req_valid = 1'($urandom);
      bus.base_load = 1'($urandom);
      bus.base_addr = AW'($urandom);
      for (int i = 0; i < n; i++) begin
         w     = (i == 0) ? w0 : w1;
         stall = (i == 0) ? s1 : s2;
         for (int c = 0; c <= stall; c++) begin
            bus.out_ready = (c == stall);
            check_eq("out_valid", 64'(bus.out_valid), 64'd1);
            check_eq("out_word", 64'(bus.out_word), 64'(w));
            check_eq("out_addr", 64'(bus.out_addr), 64'(m_addr));
            check_eq("out_last", 64'(bus.out_last), 64'(i == n - 1));
            check_eq("req_ready_busy", 64'(bus.req_ready), 64'd0);
            check_eq("err_busy", 64'(bus.err), 64'd0);
            step();
         end
         m_addr = m_addr + 1'b1;
      end
      bus.req_valid = 1'b0;
      bus.base_load = 1'b0;
      bus.out_ready = 1'b0;
      check_eq("done_valid", 64'(bus.out_valid), 64'd0);
      check_eq("done_ready", 64'(bus.req_ready), 64'd1);
   endtask

   initial begin
      logic [31:0] imm;
      int kind, sel;
      scramble_req();
      bus.req_valid = 1'b1;
      bus.base_load = 1'b0;
      bus.base_addr = '0;
      bus.out_ready = 1'b1;
      repeat (3) step();
      check_eq("rst_ready", 64'(bus.req_ready), 64'd1);
      check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_last", 64'(bus.out_last), 64'd0);
      check_eq("rst_word", 64'(bus.out_word), 64'd0);
      check_eq("rst_addr", 64'(bus.out_addr), 64'd0);
      check_eq("rst_err", 64'(bus.err), 64'd0);
      bus.req_valid = 1'b0;
      bus.out_ready = 1'b0;
      rst_b = 1'b1;
      step();

      // Directed cases.
      send(0, 0, 'h20, 1, 2, 3, 0, 32'h0, 0, 1'b0, '0, 0, 0);
      send(3, 0, 0, 0, 8, 0, 0, 32'h12345678, 0, 1'b0, '0, 0, 0);
      send(3, 0, 0, 0, 8, 0, 0, 32'h0000BEEF, 0, 1'b0, '0, 0, 0);
      send(3, 0, 0, 0, 9, 0, 0, 32'hABCD0000, 0, 1'b0, '0, 1, 0);
      send(4, 'h04, 0, 1, 2, 0, 0, 32'd4, 0, 1'b0, '0, 3, 0);
      send(7, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1'b0, '0, 0, 0);

      // Standalone base load, then a J at the top address and a wrap.
      bus.base_load = 1'b1;
      bus.base_addr = 30'h3FFFFFFF;
      step();
      bus.base_load = 1'b0;
      m_addr = 30'h3FFFFFFF;
      send(2, 'h02, 0, 0, 0, 0, 0, 32'h0, 'h0100000, 1'b0, '0, 0, 0);
      send(0, 0, 'h21, 4, 5, 6, 2, 32'h0, 0, 1'b0, '0, 0, 0);

      // Randomized requests.
      for (int r = 0; r < 200; r++) begin
         sel  = int'($urandom_range(0, 9));
         kind = (sel < 8) ? sel % 5 : 5 + int'($urandom_range(0, 2));
         case ($urandom_range(0, 3))
            0: imm = {16'h0, 16'($urandom)};
            1: imm = {16'($urandom), 16'h0};
            2: imm = $urandom;
            default: imm = 32'h0;
         endcase
         send(kind, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm,
              int'($urandom_range(0, 26'h3FFFFFF)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 1) ? AW'($urandom) : AW'(30'h3FFFFFFE),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      // Reset while the second word of an LI is pending.
      bus.req_kind  = 3'd3;
      bus.req_rt    = 5'd8;
      bus.req_imm   = 32'h12345678;
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check_eq("emit2_valid", 64'(bus.out_valid), 64'd1);
      check_eq("emit2_word", 64'(bus.out_word), 64'h35085678);
      rst_b = 1'b0;
      #1;
      check_eq("arst_valid", 64'(bus.out_valid), 64'd0);
      check_eq("arst_addr", 64'(bus.out_addr), 64'd0);
      check_eq("arst_word", 64'(bus.out_word), 64'd0);
      check_eq("arst_last", 64'(bus.out_last), 64'd0);
      check_eq("arst_ready", 64'(bus.req_ready), 64'd1);
      step();
      rst_b = 1'b1;
      bus.out_ready = 1'b1;
      m_addr = '0;
      for (int c = 0; c < 3; c++) begin
         step();
         check_eq("post_rst_idle", 64'(bus.out_valid), 64'd0);
      end
      bus.out_ready = 1'b0;
      send(1, 'h08, 0, 3, 4, 0, 0, 32'h00007FFF, 0, 1'b0, '0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
